// File: rtl/shift_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : shift_button_conditioner
// Description : Conditions the raw left/right push buttons that feed the
//               programmable blinker's shift_left / shift_right controls.
//               Each channel is synchronised (2 flops), debounced, turned
//               into a single-cycle press pulse and optionally auto-repeated
//               while held. Pulses on both channels are suppressed while both
//               buttons are held at once.
// Ports       : clk         - system clock, rising edge
//               reset       - synchronous active-high reset
//               btn_left    - raw asynchronous left button, 1 = pressed
//               btn_right   - raw asynchronous right button, 1 = pressed
//               repeat_en   - 1 = auto-repeat while a button is held
//               shift_left  - one-cycle pulse per left press / repeat
//               shift_right - one-cycle pulse per right press / repeat
//               left_held   - debounced left level
//               right_held  - debounced right level
// Revision    : 1.0 - initial release
// ============================================================================
module shift_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16,
    parameter int CNT_WIDTH       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_left,
    input  logic btn_right,
    input  logic repeat_en,
    output logic shift_left,
    output logic shift_right,
    output logic left_held,
    output logic right_held
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    // Counters run down to zero; loading N-1 makes the event land N edges
    // after the load edge.
    localparam logic [CNT_WIDTH-1:0] C_DEB_LAST    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] C_DELAY_LOAD  = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] C_PERIOD_LOAD = CNT_WIDTH'(REPEAT_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] C_ONE         = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] C_ZERO        = '0;

    // Index 0 = left channel, index 1 = right channel.
    logic [1:0] w_btn_raw;
    logic [1:0] w_held_next;
    logic [1:0] w_held_now;
    logic [1:0] w_pulse;
    logic       w_both_held;

    assign w_btn_raw = {btn_right, btn_left};

    // Conflict is judged on the levels that will hold after this edge, so a
    // simultaneous press on both channels is suppressed on its very first edge
    // and a release re-enables the other channel on the release edge itself.
    assign w_both_held = &w_held_next;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_chan
            logic                 sync1_q;
            logic                 sync2_q;
            logic                 held_q;
            logic                 held_d;
            logic [CNT_WIDTH-1:0] deb_cnt_q;
            logic [CNT_WIDTH-1:0] deb_cnt_d;
            state_e               state_q;
            state_e               state_d;
            logic [CNT_WIDTH-1:0] rep_cnt_q;
            logic [CNT_WIDTH-1:0] rep_cnt_d;
            logic                 pulse_q;
            logic                 pulse_d;
            logic                 w_rise;
            logic                 w_fall;
            logic                 w_fire;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_q   <= 1'b0;
                    sync2_q   <= 1'b0;
                    held_q    <= 1'b0;
                    deb_cnt_q <= C_ZERO;
                    state_q   <= ST_IDLE;
                    rep_cnt_q <= C_ZERO;
                    pulse_q   <= 1'b0;
                end else begin
                    sync1_q   <= w_btn_raw[i];
                    sync2_q   <= sync1_q;
                    held_q    <= held_d;
                    deb_cnt_q <= deb_cnt_d;
                    state_q   <= state_d;
                    rep_cnt_q <= rep_cnt_d;
                    pulse_q   <= pulse_d;
                end
            end

            // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive
            // edges of disagreement; any agreeing edge restarts the count.
            always_comb begin
                held_d    = held_q;
                deb_cnt_d = C_ZERO;
                if (sync2_q != held_q) begin
                    if (deb_cnt_q == C_DEB_LAST) begin
                        held_d = ~held_q;
                    end else begin
                        deb_cnt_d = deb_cnt_q + C_ONE;
                    end
                end
            end

            assign w_rise = held_d & ~held_q;
            assign w_fall = ~held_d & held_q;

            // Press / auto-repeat FSM. w_fire marks the edge a pulse is due;
            // the pulse itself is registered so outputs carry no input path.
            always_comb begin
                state_d   = state_q;
                rep_cnt_d = rep_cnt_q;
                w_fire    = 1'b0;
                if (w_fall) begin
                    state_d   = ST_IDLE;
                    rep_cnt_d = C_ZERO;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (w_rise) begin
                                w_fire    = 1'b1;
                                rep_cnt_d = C_DELAY_LOAD;
                                state_d   = ST_DELAY;
                            end
                        end
                        ST_DELAY: begin
                            // Delay keeps counting regardless of repeat_en;
                            // once expired it waits at zero for repeat_en.
                            if (rep_cnt_q != C_ZERO) begin
                                rep_cnt_d = rep_cnt_q - C_ONE;
                            end else if (repeat_en) begin
                                w_fire    = 1'b1;
                                rep_cnt_d = C_PERIOD_LOAD;
                                state_d   = ST_REPEAT;
                            end
                        end
                        ST_REPEAT: begin
                            // repeat_en low freezes the count so the period
                            // resumes where it left off.
                            if (repeat_en) begin
                                if (rep_cnt_q == C_ZERO) begin
                                    w_fire    = 1'b1;
                                    rep_cnt_d = C_PERIOD_LOAD;
                                end else begin
                                    rep_cnt_d = rep_cnt_q - C_ONE;
                                end
                            end
                        end
                        default: begin
                            state_d   = ST_IDLE;
                            rep_cnt_d = C_ZERO;
                        end
                    endcase
                end
            end

            always_comb begin
                pulse_d = w_fire & ~w_both_held;
            end

            assign w_held_next[i] = held_d;
            assign w_held_now[i]  = held_q;
            assign w_pulse[i]     = pulse_q;
        end
    endgenerate

    assign shift_left  = w_pulse[0];
    assign shift_right = w_pulse[1];
    assign left_held   = w_held_now[0];
    assign right_held  = w_held_now[1];

endmodule
`default_nettype wire

// File: tb/tb_shift_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_button_conditioner
// Description : Directed self-checking bench for shift_button_conditioner.
//               Expected pulse edges are computed from the debounce/repeat
//               timing and queued per channel; every cycle each pulse output
//               is compared against whether its queue head is due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic btn_left  = 1'b0;
    logic btn_right = 1'b0;
    logic repeat_en = 1'b0;
    logic shift_left;
    logic shift_right;
    logic left_held;
    logic right_held;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int exp_l[$];
    int exp_r[$];

    always #5 clk = ~clk;

    shift_button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .CNT_WIDTH       (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .repeat_en   (repeat_en),
        .shift_left  (shift_left),
        .shift_right (shift_right),
        .left_held   (left_held),
        .right_held  (right_held)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic mon_left();
        logic expv;
        expv = 1'b0;
        if (exp_l.size() > 0 && exp_l[0] == edge_n) begin
            expv = 1'b1;
            void'(exp_l.pop_front());
        end
        chk($sformatf("shift_left@edge%0d", edge_n), {31'd0, shift_left}, {31'd0, expv});
    endtask

    task automatic mon_right();
        logic expv;
        expv = 1'b0;
        if (exp_r.size() > 0 && exp_r[0] == edge_n) begin
            expv = 1'b1;
            void'(exp_r.pop_front());
        end
        chk($sformatf("shift_right@edge%0d", edge_n), {31'd0, shift_right}, {31'd0, expv});
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            edge_n++;
            #1;
            mon_left();
            mon_right();
        end
    endtask

    task automatic push(input int ch, input int e);
        if (ch == 0) exp_l.push_back(e);
        else         exp_r.push_back(e);
    endtask

    // Repeat slots first, first+RP, ... that fall in [lo, hi).
    task automatic push_rep(input int ch, input int first, input int lo, input int hi);
        for (int e = first; e < hi; e += RP) begin
            if (e >= lo) push(ch, e);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_shift_left"},  {31'd0, shift_left},  32'd0);
        chk({tag, "_shift_right"}, {31'd0, shift_right}, 32'd0);
        chk({tag, "_left_held"},   {31'd0, left_held},   32'd0);
        chk({tag, "_right_held"},  {31'd0, right_held},  32'd0);
    endtask

    initial begin
        int base;

        // Reset, then idle: nothing may move.
        step(4);
        chk_all_zero("reset");
        reset = 1'b0;
        step(20);
        chk_all_zero("idle");

        // Single left press: pulse D+2 edges after the input changes.
        base = edge_n;
        btn_left = 1'b1;
        push(0, base + D + 2);
        step(D + 1);
        chk("left_held_before_qualify", {31'd0, left_held}, 32'd0);
        step(1);
        chk("left_held_after_qualify", {31'd0, left_held}, 32'd1);
        step(14);
        btn_left = 1'b0;
        step(D + 1);
        chk("left_held_before_release", {31'd0, left_held}, 32'd1);
        step(1);
        chk("left_held_after_release", {31'd0, left_held}, 32'd0);
        step(6);

        // Bouncing right press: one pulse after the last rising bounce.
        btn_right = 1'b1; step(1);
        btn_right = 1'b0; step(1);
        btn_right = 1'b1; step(1);
        btn_right = 1'b0; step(1);
        btn_right = 1'b1;
        base = edge_n;
        push(1, base + D + 2);
        step(D + 1);
        chk("right_held_bounce_before", {31'd0, right_held}, 32'd0);
        step(1);
        chk("right_held_bounce_after", {31'd0, right_held}, 32'd1);
        step(6);
        btn_right = 1'b0;
        step(D + 2);
        chk("right_held_bounce_release", {31'd0, right_held}, 32'd0);
        step(2);

        // Glitch one cycle shorter than the debounce window.
        btn_right = 1'b1;
        step(D - 1);
        btn_right = 1'b0;
        step(D + 4);
        chk("right_held_glitch", {31'd0, right_held}, 32'd0);

        // Auto-repeat while held for 40 cycles.
        repeat_en = 1'b1;
        base = edge_n;
        btn_left = 1'b1;
        push(0, base + D + 2);
        push_rep(0, base + D + 2 + RD, 0, base + 40 + D + 2);
        step(40);
        btn_left = 1'b0;
        step(D + 1);
        chk("left_held_repeat_before_release", {31'd0, left_held}, 32'd1);
        step(1);
        chk("left_held_repeat_after_release", {31'd0, left_held}, 32'd0);
        step(6);

        // Both pressed together: all suppressed until right releases, then
        // left repeats resume on their schedule (including the release edge).
        base = edge_n;
        btn_left  = 1'b1;
        btn_right = 1'b1;
        push_rep(0, base + D + 2 + RD, base + 20 + D + 2, base + 40 + D + 2);
        step(D + 2);
        chk("conflict_left_held",  {31'd0, left_held},  32'd1);
        chk("conflict_right_held", {31'd0, right_held}, 32'd1);
        step(20 - (D + 2));
        btn_right = 1'b0;
        step(20);
        btn_left = 1'b0;
        step(D + 2);
        chk("conflict_left_released",  {31'd0, left_held},  32'd0);
        chk("conflict_right_released", {31'd0, right_held}, 32'd0);
        step(4);

        // repeat_en dropped for 10 cycles mid-REPEAT: the slot due at
        // base+26 slides by exactly 10 edges.
        base = edge_n;
        btn_left = 1'b1;
        push(0, base + D + 2);
        push(0, base + 14);
        push(0, base + 18);
        push(0, base + 22);
        push_rep(0, base + 36, 0, base + 50 + D + 2);
        step(24);
        repeat_en = 1'b0;
        step(10);
        repeat_en = 1'b1;
        step(16);
        btn_left = 1'b0;
        step(D + 2);
        chk("pause_left_released", {31'd0, left_held}, 32'd0);
        step(4);

        // Reset mid-repeat with the button still down: outputs clear, the
        // pending slot is dropped, and the held button re-qualifies afresh.
        base = edge_n;
        btn_left = 1'b1;
        push(0, base + D + 2);
        push(0, base + 14);
        push(0, base + 18);
        step(20);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        repeat_en = 1'b0;
        chk_all_zero("midreset");
        push(0, edge_n + D + 2);
        step(D + 2);
        chk("midreset_left_held_requalified", {31'd0, left_held}, 32'd1);
        btn_left = 1'b0;
        step(D + 2);
        chk("midreset_left_released", {31'd0, left_held}, 32'd0);
        step(10);

        chk("left_queue_drained",  exp_l.size(), 32'd0);
        chk("right_queue_drained", exp_r.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_button_conditioner.md
Name: shift_button_conditioner

Overview:
Conditions the two raw push-button inputs that drive the programmable blinker's shift_left / shift_right controls. Each channel is synchronised, debounced, converted to a single-cycle press pulse, and optionally auto-repeated while held. Sits directly upstream of programmable_blinker; its shift_left/shift_right outputs connect straight to the blinker's ports of the same name. Shares the blinker's clock domain.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive clocks a synchronised input must differ from the debounced level before the level flips (min 1)
REPEAT_DELAY, 64, clocks from the press pulse to the first auto-repeat pulse (min 2)
REPEAT_PERIOD, 16, clocks between successive auto-repeat pulses (min 2)
CNT_WIDTH, 8, width of every internal counter; all three counts above must be <= 2^CNT_WIDTH - 1

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
btn_left  input  1  raw asynchronous left button, 1 = pressed
btn_right  input  1  raw asynchronous right button, 1 = pressed
repeat_en  input  1  1 = auto-repeat enabled while a button is held
shift_left  output  1  one-cycle pulse per left press / repeat
shift_right  output  1  one-cycle pulse per right press / repeat
left_held  output  1  debounced left level
right_held  output  1  debounced right level

Behaviour:
- Reset (sampled on clk rising edge while reset=1): synchroniser flops, debounced levels, all counters, pulse registers -> 0; both channel FSMs -> IDLE. All outputs 0 in the cycle after the reset edge. Reset mid-debounce or mid-repeat discards all progress; no pulse is emitted on or after the reset edge until a fresh press qualifies.
- Per channel, identical and independent except for the conflict rule:
  - Synchroniser: 2 flops; sync2 = raw delayed 2 edges.
  - Debounce: counter increments on each edge where sync2 != held; clears on any edge where sync2 == held. On the edge where a mismatch is seen with counter == DEBOUNCE_CYCLES-1, held toggles and counter clears. Glitches shorter than DEBOUNCE_CYCLES edges never change held.
  - Latency: raw rises before edge k and stays high -> held and press pulse first visible after edge k+1+DEBOUNCE_CYCLES.
- Channel FSM (registered pulse output, high exactly one cycle):
  - IDLE: on the edge held rises -> pulse=1, load repeat counter, go DELAY.
  - DELAY: counts REPEAT_DELAY edges from the press pulse; on expiry, if repeat_en=1 -> pulse=1, go REPEAT; if repeat_en=0 -> stay in DELAY with counter saturated (no pulse), pulse issued on the first edge repeat_en is seen 1.
  - REPEAT: pulse every REPEAT_PERIOD edges while repeat_en=1; repeat_en=0 freezes the counter, no pulses.
  - Any state: held falls -> IDLE on that edge, counter cleared, no pulse.
- Conflict: while both held levels are 1, every pulse (press or repeat) on both channels is suppressed; FSMs still advance. If both held levels rise on the same edge, neither press pulse is emitted. Releasing one button does not retroactively emit the other's press pulse; repeats for the still-held channel resume on its next scheduled slot.
- left_held/right_held are the debounced levels, unaffected by the conflict rule.
- No combinational path from any input to any output.

Test Plan:
(DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4, repeat_en=0 unless stated)
1. Reset 4 cycles, then idle 20 cycles -> all outputs 0 throughout; assert reset for 1 cycle mid-repeat -> outputs 0 next cycle, no pulse until re-press qualifies.
2. btn_left rises before edge 10, held 20 cycles -> left_held=1 and shift_left=1 for exactly one cycle after edge 15; no further shift_left; left_held=0 after release edge + 6.
3. btn_right bounces 1,0,1,0,1 (one cycle each), then stable 1 -> exactly one shift_right pulse, 6 edges after the last 0->1 transition; 3-cycle glitch alone -> no pulse, right_held stays 0.
4. repeat_en=1, btn_left held 40 cycles -> press pulse at cycle P, repeats at P+8, P+12, P+16, ...; release -> no pulses after left_held falls.
5. btn_left and btn_right rise together -> no pulses on either; release right while left held with repeat_en=1 -> left repeats resume on next scheduled slot, no catch-up press pulse.
6. repeat_en=1 then cleared mid-REPEAT for 10 cycles, then set -> pulses stop while 0, resume with remaining period count.
